// File: rtl/turbo_deinterleaver_if.sv
// Stream bundle for the QPP de-interleaver: interleaved samples in, natural-order samples out.
// A beat moves only on a posedge where valid && ready; a raised valid holds its data until taken.
interface turbo_deinterleaver_if #(
  parameter int DATA_W = 1
);
  logic              k_eq_6144;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  modport master (
    output k_eq_6144, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  k_eq_6144, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/turbo_deinterleaver.sv
// Streaming LTE QPP de-interleaver: writes each interleaved sample to address pi(i),
// then reads the single 6144-entry buffer back in natural order.
module turbo_deinterleaver #(
  parameter int DATA_W = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  turbo_deinterleaver_if.slave bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [12:0] K_BIG    = 13'd6144;
  localparam logic [12:0] K_SMALL  = 13'd1056;
  localparam logic [12:0] G0_BIG   = 13'd743;
  localparam logic [12:0] G0_SMALL = 13'd83;
  localparam logic [12:0] ST_BIG   = 13'd960;
  localparam logic [12:0] ST_SMALL = 13'd132;

  state_t            state;
  state_t            state_nxt;
  logic              k_big;
  logic [12:0]       cnt;
  logic [12:0]       pi;
  logic [12:0]       g;
  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] mem [0:6143];

  logic              in_ready;
  logic              in_acc;
  logic              out_acc;
  logic              rd_en;
  logic [12:0]       k_val;
  logic [12:0]       step;
  logic [12:0]       k_in;
  logic [12:0]       g0_in;
  logic [12:0]       step_in;
  logic [12:0]       wr_addr;

  // Sum of two residues mod k; one conditional subtract suffices since both are < k.
  function automatic logic [12:0] mod_add(input logic [12:0] a, input logic [12:0] b,
                                          input logic [12:0] k);
    logic [13:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) begin
      s = s - {1'b0, k};
    end
    return s[12:0];
  endfunction

  assign k_val   = k_big ? K_BIG : K_SMALL;
  assign step    = k_big ? ST_BIG : ST_SMALL;
  assign k_in    = bus.k_eq_6144 ? K_BIG : K_SMALL;
  assign g0_in   = bus.k_eq_6144 ? G0_BIG : G0_SMALL;
  assign step_in = bus.k_eq_6144 ? ST_BIG : ST_SMALL;

  assign in_ready = (state != DRAIN);
  assign in_acc   = bus.in_valid && in_ready;
  assign out_acc  = out_valid_q && bus.out_ready;
  // cnt doubles as the read address during DRAIN; reading stops once it reaches K.
  assign rd_en    = (state == DRAIN) && (cnt != k_val) && (!out_valid_q || bus.out_ready);
  assign wr_addr  = (state == IDLE) ? 13'd0 : pi;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_acc) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (in_acc && (cnt == k_val - 13'd1)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_acc && out_last_q) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k_big <= 1'b0;
      cnt   <= 13'd0;
      pi    <= 13'd0;
      g     <= 13'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_acc) begin
            k_big <= bus.k_eq_6144;
            cnt   <= 13'd1;
            pi    <= g0_in;
            g     <= mod_add(g0_in, step_in, k_in);
          end
        end
        LOAD: begin
          if (in_acc) begin
            pi  <= mod_add(pi, g, k_val);
            g   <= mod_add(g, step, k_val);
            cnt <= (cnt == k_val - 13'd1) ? 13'd0 : cnt + 13'd1;
          end
        end
        DRAIN: begin
          if (out_acc && out_last_q) begin
            cnt <= 13'd0;
            pi  <= 13'd0;
            g   <= 13'd0;
          end else if (rd_en) begin
            cnt <= cnt + 13'd1;
          end
        end
        default: begin
          cnt <= 13'd0;
        end
      endcase
    end
  end

  // out_valid/out_last follow the read register: set by a read, cleared by an accept with no refill.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (rd_en) begin
      out_valid_q <= 1'b1;
      out_last_q  <= (cnt == k_val - 13'd1);
    end else if (out_acc) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (in_acc) begin
      mem[wr_addr] <= bus.in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[cnt];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = rd_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_turbo_deinterleaver.sv
// Directed bench for turbo_deinterleaver: blocks fed in QPP order, natural-order output checked
// against a direct-formula pi model.
module tb_turbo_deinterleaver;
  localparam int DW = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic [DW-1:0] exp_q[$];
  bit         vec [6144];

  turbo_deinterleaver_if #(.DATA_W(DW)) bus ();

  turbo_deinterleaver #(.DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock/reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // pi(i) = (f1*i + f2*i^2) mod K computed directly
  function automatic int pi_of(input int i, input int k);
    longint f1;
    longint f2;
    f1 = (k == 6144) ? 263 : 17;
    f2 = (k == 6144) ? 480 : 66;
    return int'((f1 * i + f2 * i * i) % k);
  endfunction

  // driver tasks
  task automatic feed(input logic k6144, input logic [DW-1:0] d, input bit gaps);
    bit acc;
    int cyc;
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        tick();
      end
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.k_eq_6144 = k6144;
    cyc = 0;
    do begin
      acc = bus.in_ready;
      tick();
      cyc++;
    end while (!acc && cyc < 50);
    if (!acc) check("in_accept_timeout", 32'(cyc), 32'(0));
    bus.in_valid = 1'b0;
  endtask

  task automatic load_block(input int k, input int n, input bit rt, input bit gaps,
                            input int flip_at);
    int p;
    logic [DW-1:0] d;
    logic ksel;
    for (int i = 0; i < n; i++) begin
      p = pi_of(i, k);
      d = rt ? DW'(vec[p]) : DW'(p);
      ksel = (i < flip_at) ? (k == 6144) : (k != 6144);
      feed(ksel, d, gaps);
    end
  endtask

  task automatic expect_block(input int k, input bit rt);
    exp_q.delete();
    for (int j = 0; j < k; j++) begin
      exp_q.push_back(rt ? DW'(vec[j]) : DW'(j));
    end
  endtask

  // scoreboard-side drain: pops exp_q on every accepted beat
  task automatic drain_block(input int k, input bit rnd);
    int j;
    int cyc;
    bit stalled;
    logic [DW-1:0] held;
    logic [DW-1:0] exp;
    j = 0;
    cyc = 0;
    stalled = 0;
    held = '0;
    while (j < k && cyc < 4 * k + 100) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check("in_ready_drain", 32'(bus.in_ready), 32'(0));
      check("last_without_valid", 32'(bus.out_last & ~bus.out_valid), 32'(0));
      if (stalled) begin
        check("stall_valid", 32'(bus.out_valid), 32'(1));
        check("stall_data", 32'(bus.out_data), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("exp_underflow", 32'(j), 32'(k));
          exp = '0;
        end else begin
          exp = exp_q.pop_front();
        end
        check("out_data", 32'(bus.out_data), 32'(exp));
        check("out_last", 32'(bus.out_last), 32'(j == k - 1));
        j++;
        stalled = 0;
      end else if (bus.out_valid) begin
        stalled = 1;
        held = bus.out_data;
      end else begin
        stalled = 0;
      end
      tick();
      cyc++;
    end
    check("drain_count", 32'(j), 32'(k));
    bus.out_ready = 1'b0;
    check("post_in_ready", 32'(bus.in_ready), 32'(1));
    check("post_out_valid", 32'(bus.out_valid), 32'(0));
    check("post_busy", 32'(bus.busy), 32'(0));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.k_eq_6144 = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_out_last", 32'(bus.out_last), 32'(0));
    check("rst_out_data", 32'(bus.out_data), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_state", 32'(state_dbg), 32'(0));

    // K=1056, sample i = pi(i)
    expect_block(1056, 0);
    load_block(1056, 1056, 0, 0, 1056);
    check("t1_prefetch_valid", 32'(bus.out_valid), 32'(0));
    drain_block(1056, 0);

    // K=6144, prefetch cycle then first valid
    expect_block(6144, 0);
    load_block(6144, 6144, 0, 0, 6144);
    check("t2_prefetch_valid", 32'(bus.out_valid), 32'(0));
    check("t2_prefetch_state", 32'(state_dbg), 32'(2));
    check("t2_prefetch_busy", 32'(bus.busy), 32'(1));
    tick();
    check("t2_first_valid", 32'(bus.out_valid), 32'(1));
    drain_block(6144, 0);

    // back-to-back, k_eq_6144 dropped mid-LOAD of the first block
    expect_block(6144, 0);
    load_block(6144, 6144, 0, 0, 3000);
    drain_block(6144, 0);
    expect_block(1056, 0);
    load_block(1056, 1056, 0, 0, 1056);
    drain_block(1056, 0);

    // random input gaps and random out_ready
    expect_block(1056, 0);
    load_block(1056, 1056, 0, 1, 1056);
    drain_block(1056, 1);

    // reset at input sample 500 of a K=6144 block
    load_block(6144, 500, 0, 0, 6144);
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(pi_of(500, 6144));
    bus.k_eq_6144 = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_in_ready", 32'(bus.in_ready), 32'(1));
    check("t5_out_valid", 32'(bus.out_valid), 32'(0));
    check("t5_busy", 32'(bus.busy), 32'(0));
    check("t5_state", 32'(state_dbg), 32'(0));
    expect_block(1056, 0);
    load_block(1056, 1056, 0, 0, 1056);
    drain_block(1056, 0);

    // round trip of a random 6144-bit vector
    for (int j = 0; j < 6144; j++) vec[j] = 1'($urandom_range(0, 1));
    expect_block(6144, 1);
    load_block(6144, 6144, 1, 0, 6144);
    drain_block(6144, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
